// File: rtl/spi_burst_sequencer.sv
// rtl/spi_burst_sequencer.sv - burst feeder for an 8-bit SPI master with TX/RX byte buffers
module spi_burst_sequencer #(
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 1023
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [7:0]               wr_data,
   input  logic                     go,
   input  logic                     rx_rd_en,
   output logic [7:0]               rx_data,
   output logic [$clog2(DEPTH):0]   tx_count,
   output logic [$clog2(DEPTH):0]   rx_count,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic                     spi_start,
   output logic [7:0]               spi_data,
   input  logic                     spi_ss,
   input  logic [7:0]               spi_rx
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_REQ, S_XFER, S_STORE, S_DONE, S_ERR
   } state_t;

   state_t          state;
   logic [7:0]      tx_buf [DEPTH];
   logic [7:0]      rx_buf [DEPTH];
   logic [PW-1:0]   idx;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   rd_nxt;
   logic [TW-1:0]   timer;
   logic            ss_meta;
   logic            ss_s;
   logic            wr_ok;
   logic            start_ok;
   logic            pop;
   logic [CW-1:0]   tx_eff;
   logic [7:0]      rx_nxt;

   // A write in the same cycle as go is counted before the burst length is taken.
   always_comb begin
      wr_ok    = (state == S_IDLE) && wr_en && (tx_count < CW'(DEPTH));
      tx_eff   = tx_count + {{(CW-1){1'b0}}, wr_ok};
      start_ok = (state == S_IDLE) && go && (tx_eff != '0);
      pop      = !busy && rx_rd_en && (rx_count != '0) && !start_ok;
      rd_nxt   = rd_ptr;
      if (start_ok)
         rd_nxt = '0;
      else if (pop)
         rd_nxt = rd_ptr + PW'(1);
      // rx_data must track the head even when the head slot is being written now.
      rx_nxt = ((state == S_STORE) && (idx == rd_nxt)) ? spi_rx : rx_buf[rd_nxt];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         ss_meta   <= 1'b1;
         ss_s      <= 1'b1;
         rx_data   <= 8'h00;
         tx_count  <= '0;
         rx_count  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         spi_start <= 1'b0;
         spi_data  <= 8'h00;
         idx       <= '0;
         rd_ptr    <= '0;
         timer     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            tx_buf[i] <= 8'h00;
            rx_buf[i] <= 8'h00;
         end
      end else begin
         ss_meta <= spi_ss;
         ss_s    <= ss_meta;
         done    <= 1'b0;
         rd_ptr  <= rd_nxt;
         rx_data <= rx_nxt;
         if (pop)
            rx_count <= rx_count - CW'(1);
         if (wr_ok) begin
            tx_buf[tx_count[PW-1:0]] <= wr_data;
            tx_count                 <= tx_eff;
         end
         case (state)
            S_IDLE: begin
               if (start_ok) begin
                  err      <= 1'b0;
                  rx_count <= '0;
                  idx      <= '0;
                  busy     <= 1'b1;
                  state    <= S_LOAD;
               end else if (go) begin
                  done <= 1'b1;
               end
            end
            S_LOAD: begin
               spi_data  <= tx_buf[idx];
               timer     <= '0;
               spi_start <= 1'b1;
               state     <= S_REQ;
            end
            S_REQ: begin
               if (!ss_s) begin
                  spi_start <= 1'b0;
                  timer     <= '0;
                  state     <= S_XFER;
               end else if (timer == TW'(TIMEOUT)) begin
                  spi_start <= 1'b0;
                  state     <= S_ERR;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            S_XFER: begin
               if (ss_s)
                  state <= S_STORE;
               else if (timer == TW'(TIMEOUT))
                  state <= S_ERR;
               else
                  timer <= timer + TW'(1);
            end
            S_STORE: begin
               rx_buf[idx] <= spi_rx;
               rx_count    <= rx_count + CW'(1);
               idx         <= idx + PW'(1);
               state       <= ({1'b0, idx} == tx_count - CW'(1)) ? S_DONE : S_LOAD;
            end
            S_DONE: begin
               done     <= 1'b1;
               busy     <= 1'b0;
               tx_count <= '0;
               state    <= S_IDLE;
            end
            S_ERR: begin
               err       <= 1'b1;
               busy      <= 1'b0;
               spi_start <= 1'b0;
               tx_count  <= '0;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_burst_sequencer.sv
// tb/tb_spi_burst_sequencer.sv - randomized bench with an SPI master model and burst reference model
module tb_spi_burst_sequencer;
   localparam int DEPTH   = 8;
   localparam int TIMEOUT = 40;
   localparam int CW      = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic [7:0]    wr_data = 8'h00;
   logic          go = 1'b0;
   logic          rx_rd_en = 1'b0;
   logic [7:0]    rx_data;
   logic [CW-1:0] tx_count;
   logic [CW-1:0] rx_count;
   logic          busy, done, err, spi_start;
   logic [7:0]    spi_data;
   logic          spi_ss;
   logic [7:0]    spi_rx;

   int checks = 0;
   int errors = 0;

   // Master model state: mode 0 normal, 1 never asserts SS, 2 holds SS low on frame hang_frame.
   int         mode = 0;
   int         hang_frame = 0;
   int         starts = 0;
   logic [7:0] sent_q[$];
   logic [7:0] resp_q[$];

   int done_cnt = 0;
   int busy_cycles = 0;
   int start_cycles = 0;

   spi_burst_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .go(go),
      .rx_rd_en(rx_rd_en), .rx_data(rx_data), .tx_count(tx_count), .rx_count(rx_count),
      .busy(busy), .done(done), .err(err), .spi_start(spi_start), .spi_data(spi_data),
      .spi_ss(spi_ss), .spi_rx(spi_rx)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b1) busy_cycles++;
      if (spi_start === 1'b1) start_cycles++;
   end

   initial begin
      spi_ss = 1'b1;
      spi_rx = 8'h00;
      forever begin
         int frame;
         @(posedge spi_start);
         #1;
         frame = starts;
         starts++;
         sent_q.push_back(spi_data);
         if (mode != 1) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            spi_ss = 1'b0;
            if (!(mode == 2 && frame == hang_frame)) begin
               repeat ($urandom_range(1, 5)) @(negedge clk);
               spi_rx = (resp_q.size() > 0) ? resp_q.pop_front() : 8'h00;
               @(negedge clk);
               spi_ss = 1'b1;
            end
         end
      end
   end

   task automatic push_byte(input logic [7:0] b);
      wr_en = 1'b1; wr_data = b;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic pulse_go;
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
   endtask

   task automatic pop_byte;
      rx_rd_en = 1'b1;
      @(negedge clk);
      rx_rd_en = 1'b0;
   endtask

   task automatic wait_not_busy(input int budget, output bit ok);
      int n = 0;
      while (busy !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      ok = (busy === 1'b0);
   endtask

   task automatic test_reset;
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
      checks++; if (tx_count !== '0) begin errors++; $display("FAIL reset_tx_count got %0d want 0", tx_count); end
      checks++; if (rx_count !== '0) begin errors++; $display("FAIL reset_rx_count got %0d want 0", rx_count); end
      checks++; if ({busy, done, err, spi_start} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", {busy, done, err, spi_start}); end
      checks++; if (spi_data !== 8'h00) begin errors++; $display("FAIL reset_spi_data got %h want 00", spi_data); end
   endtask

   task automatic test_empty_go;
      int d0 = done_cnt, b0 = busy_cycles, s0 = start_cycles, st0 = starts;
      pulse_go;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL empty_go_done got %b want 1", done); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL empty_go_done_width got %b want 0", done); end
      repeat (4) @(negedge clk);
      checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL empty_go_pulses got %0d want 1", done_cnt - d0); end
      checks++; if (busy_cycles != b0 || start_cycles != s0 || starts != st0) begin
         errors++; $display("FAIL empty_go_activity busy %0d start %0d frames %0d want 0", busy_cycles - b0, start_cycles - s0, starts - st0);
      end
   endtask

   // Reference: frames carry the first min(n,DEPTH) written bytes; RX holds the master's replies in order.
   task automatic run_burst(input int n, input bit merge_go, input string name);
      logic [7:0] expq[$];
      logic [7:0] rsp[$];
      logic [7:0] b;
      int exp_cnt, d0;
      bit ok;
      exp_cnt = (n < DEPTH) ? n : DEPTH;
      starts = 0; sent_q.delete(); resp_q.delete();
      for (int k = 0; k < exp_cnt; k++) begin
         b = 8'($urandom);
         rsp.push_back(b);
         resp_q.push_back(b);
      end
      for (int k = 0; k < n; k++) begin
         b = 8'($urandom);
         if (k < DEPTH) expq.push_back(b);
         if (merge_go && k == n - 1) begin
            wr_en = 1'b1; wr_data = b; go = 1'b1;
            @(negedge clk);
            wr_en = 1'b0; go = 1'b0;
         end else begin
            push_byte(b);
         end
      end
      if (!merge_go) begin
         checks++; if (tx_count !== CW'(exp_cnt)) begin errors++; $display("FAIL %s tx_count got %0d want %0d", name, tx_count, exp_cnt); end
         pulse_go;
      end
      d0 = done_cnt;
      wait_not_busy(exp_cnt * 40 + 50, ok);
      checks++; if (!ok) begin errors++; $display("FAIL %s timeout busy got %b want 0", name, busy); end
      @(negedge clk);
      checks++; if (starts != exp_cnt) begin errors++; $display("FAIL %s frames got %0d want %0d", name, starts, exp_cnt); end
      for (int k = 0; k < exp_cnt && k < sent_q.size(); k++) begin
         checks++; if (sent_q[k] !== expq[k]) begin errors++; $display("FAIL %s spi_data[%0d] got %h want %h", name, k, sent_q[k], expq[k]); end
      end
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL %s done_pulses got %0d want 1", name, done_cnt - d0); end
      checks++; if (rx_count !== CW'(exp_cnt) || tx_count !== '0 || err !== 1'b0) begin
         errors++; $display("FAIL %s counts rx %0d tx %0d err %b want rx %0d tx 0 err 0", name, rx_count, tx_count, err, exp_cnt);
      end
      for (int k = 0; k < exp_cnt; k++) begin
         checks++; if (rx_data !== rsp[k]) begin errors++; $display("FAIL %s rx_data[%0d] got %h want %h", name, k, rx_data, rsp[k]); end
         pop_byte;
      end
      checks++; if (rx_count !== '0) begin errors++; $display("FAIL %s rx_count_after_pops got %0d want 0", name, rx_count); end
   endtask

   task automatic test_basic_burst;
      logic [7:0] tx[3] = '{8'hA5, 8'h3C, 8'hFF};
      logic [7:0] rx[3] = '{8'h11, 8'h22, 8'h33};
      int d0, s0;
      bit ok;
      starts = 0; sent_q.delete(); resp_q.delete();
      for (int k = 0; k < 3; k++) begin
         resp_q.push_back(rx[k]);
         push_byte(tx[k]);
      end
      s0 = start_cycles; d0 = done_cnt;
      pulse_go;
      wait_not_busy(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL basic timeout busy got %b want 0", busy); end
      @(negedge clk);
      checks++; if (starts != 3) begin errors++; $display("FAIL basic frames got %0d want 3", starts); end
      for (int k = 0; k < 3 && k < sent_q.size(); k++) begin
         checks++; if (sent_q[k] !== tx[k]) begin errors++; $display("FAIL basic spi_data[%0d] got %h want %h", k, sent_q[k], tx[k]); end
      end
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic done_pulses got %0d want 1", done_cnt - d0); end
      checks++; if (rx_count !== CW'(3)) begin errors++; $display("FAIL basic rx_count got %0d want 3", rx_count); end
      for (int k = 0; k < 3; k++) begin
         checks++; if (rx_data !== rx[k]) begin errors++; $display("FAIL basic rx_data[%0d] got %h want %h", k, rx_data, rx[k]); end
         pop_byte;
      end
      checks++; if (rx_count !== '0) begin errors++; $display("FAIL basic rx_count_end got %0d want 0", rx_count); end
      pop_byte;
      checks++; if (rx_count !== '0) begin errors++; $display("FAIL basic empty_pop got %0d want 0", rx_count); end
   endtask

   task automatic test_random_bursts;
      run_burst(9, 1'b0, "overflow9");
      run_burst(DEPTH, 1'b0, "full");
      run_burst(int'($urandom_range(1, DEPTH - 1)), 1'b1, "wr_with_go");
      for (int it = 0; it < 4; it++)
         run_burst(int'($urandom_range(1, DEPTH + 2)), 1'b0, "random");
   endtask

   task automatic test_timeout;
      int s0;
      bit ok;
      logic [7:0] r;
      mode = 1; starts = 0; sent_q.delete(); resp_q.delete();
      push_byte(8'h5A);
      push_byte(8'h6B);
      s0 = start_cycles;
      pulse_go;
      wait_not_busy(TIMEOUT + 60, ok);
      checks++; if (!ok) begin errors++; $display("FAIL timeout_busy got %b want 0", busy); end
      checks++; if (err !== 1'b1 || spi_start !== 1'b0 || tx_count !== '0) begin
         errors++; $display("FAIL timeout_state err %b start %b tx %0d want 1 0 0", err, spi_start, tx_count);
      end
      checks++; if (start_cycles - s0 != TIMEOUT + 1) begin errors++; $display("FAIL timeout_req_cycles got %0d want %0d", start_cycles - s0, TIMEOUT + 1); end
      mode = 0; starts = 0; sent_q.delete();
      r = 8'($urandom);
      resp_q.push_back(r);
      push_byte(8'hC3);
      pulse_go;
      checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL timeout_recover_go err %b busy %b want 0 1", err, busy); end
      wait_not_busy(200, ok);
      @(negedge clk);
      checks++; if (!ok || err !== 1'b0 || rx_count !== CW'(1) || rx_data !== r) begin
         errors++; $display("FAIL timeout_recover_end err %b rx_count %0d rx_data %h want 0 1 %h", err, rx_count, rx_data, r);
      end
      pop_byte;
   endtask

   task automatic test_hang_mid_burst;
      logic [7:0] r[3];
      int n;
      bit ok;
      mode = 2; hang_frame = 1; starts = 0; sent_q.delete(); resp_q.delete();
      for (int k = 0; k < 3; k++) begin
         r[k] = 8'($urandom);
         resp_q.push_back(r[k]);
         push_byte(8'($urandom));
      end
      pulse_go;
      n = 0;
      while (starts < 2 && n < 300) begin @(negedge clk); n++; end
      checks++; if (starts < 2) begin errors++; $display("FAIL hang_second_frame got %0d frames want 2", starts); end
      repeat (6) @(negedge clk);
      push_byte(8'h77);
      pulse_go;
      pop_byte;
      checks++; if (tx_count !== CW'(3) || busy !== 1'b1) begin errors++; $display("FAIL hang_busy_ignore tx %0d busy %b want 3 1", tx_count, busy); end
      wait_not_busy(TIMEOUT + 60, ok);
      @(negedge clk);
      checks++; if (!ok || err !== 1'b1) begin errors++; $display("FAIL hang_err got %b want 1", err); end
      checks++; if (rx_count !== CW'(1) || rx_data !== r[0]) begin
         errors++; $display("FAIL hang_rx rx_count %0d rx_data %h want 1 %h", rx_count, rx_data, r[0]);
      end
      checks++; if (starts != 2 || tx_count !== '0) begin errors++; $display("FAIL hang_frames %0d tx %0d want 2 0", starts, tx_count); end
      spi_ss = 1'b1; mode = 0; resp_q.delete();
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid_xfer;
      int n;
      mode = 2; hang_frame = 2; starts = 0; sent_q.delete(); resp_q.delete();
      for (int k = 0; k < 3; k++) begin
         resp_q.push_back(8'($urandom));
         push_byte(8'($urandom));
      end
      pulse_go;
      n = 0;
      while (!(starts == 3 && spi_ss == 1'b0) && n < 300) begin @(negedge clk); n++; end
      checks++; if (starts != 3) begin errors++; $display("FAIL rst_mid_reach got %0d frames want 3", starts); end
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || spi_start !== 1'b0) begin errors++; $display("FAIL rst_mid_async busy %b start %b want 0 0", busy, spi_start); end
      @(negedge clk);
      rst = 1'b0;
      spi_ss = 1'b1; mode = 0; resp_q.delete();
      @(negedge clk);
      checks++; if (tx_count !== '0 || rx_count !== '0 || busy !== 1'b0 || spi_start !== 1'b0) begin
         errors++; $display("FAIL rst_mid_state tx %0d rx %0d busy %b start %b want 0 0 0 0", tx_count, rx_count, busy, spi_start);
      end
      repeat (3) @(negedge clk);
      test_empty_go();
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      test_reset();
      test_empty_go();
      test_basic_burst();
      test_random_bursts();
      test_timeout();
      test_hang_mid_burst();
      test_reset_mid_xfer();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/spi_burst_sequencer.md
Name: spi_burst_sequencer

Overview:
- Upstream feeder for the 8-bit SPI master.
- Host software/logic preloads a burst of up to DEPTH bytes, then pulses go.
- The sequencer hands each byte to the master with a start/acknowledge handshake, waits for the frame to complete (SS returns high), and captures each received byte into an RX buffer for readback.

Parameters:
- DEPTH, 8, number of bytes held in each of the TX and RX buffers (power of 2, 2..16).
- TIMEOUT, 1023, clk cycles allowed for the master to assert SS, or to release it, before err is raised.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous reset, active-high.
- wr_en  input  1  push wr_data into the TX buffer.
- wr_data  input  8  TX byte.
- go  input  1  start the burst; sampled only in IDLE.
- rx_rd_en  input  1  pop one byte from the RX buffer.
- rx_data  output  8  RX buffer head byte (registered).
- tx_count  output  clog2(DEPTH)+1  bytes loaded.
- rx_count  output  clog2(DEPTH)+1  unread RX bytes.
- busy  output  1  high from go acceptance until DONE/ERR.
- done  output  1  one-cycle pulse when the burst completes.
- err  output  1  sticky timeout flag; cleared by the next accepted go or rst.
- spi_start  output  1  start request to the master.
- spi_data  output  8  byte presented to the master (datoIN).
- spi_ss  input  1  master SS (active-low); asynchronous to clk.
- spi_rx  input  8  master received byte (datoOUT); stable while spi_ss is high.

Behaviour:
- Reset values:
  - rx_data=0, tx_count=0, rx_count=0.
  - busy=0, done=0, err=0.
  - spi_start=0, spi_data=0.
  - Pointers 0.
  - spi_ss synchronizer flops=1.
  - state=IDLE.
- Reset mid-burst aborts immediately. spi_start drops asynchronously. Buffers are emptied.
- spi_ss passes through a 2-flop synchronizer. ss_s denotes the synchronized value; all decisions below use ss_s.
- TX buffer:
  - wr_en accepted only in IDLE with tx_count<DEPTH. Data is written at tx_count, and tx_count increments.
  - wr_en when full or not IDLE is ignored; no state change.
- States:
  - IDLE:
    - go with tx_count=0: done pulses next cycle, no SPI activity, state stays IDLE.
    - go with tx_count>0: clear err, rx_count, RX pointers and the byte index idx. Set busy and go to LOAD.
  - LOAD: spi_data <= tx_buf[idx]. Clear the timer. Go to REQ.
  - REQ:
    - spi_start=1.
    - On ss_s==0: spi_start <= 0, clear the timer, go to XFER.
    - If the timer reaches TIMEOUT: go to ERR.
  - XFER:
    - spi_start=0.
    - On ss_s==1: go to STORE.
    - If the timer reaches TIMEOUT: go to ERR.
  - STORE:
    - rx_buf[idx] <= spi_rx, rx_count++, idx++.
    - If idx==tx_count-1 go to DONE, else go to LOAD.
  - DONE: done=1 for one cycle. busy <= 0. tx_count <= 0, so the TX buffer is consumed. Go to IDLE.
  - ERR: err <= 1 (sticky). busy <= 0. spi_start <= 0. tx_count <= 0. Bytes already stored stay readable. Go to IDLE.
- spi_data is held constant from LOAD through STORE.
- spi_start is high only in REQ.
- RX readback:
  - Allowed only while not busy.
  - rx_data always reflects rx_buf[rd_ptr].
  - rx_rd_en with rx_count>0 advances rd_ptr and decrements rx_count.
  - rx_rd_en with rx_count=0 is ignored.
  - rx_rd_en while busy is ignored.
- Simultaneous wr_en and go in IDLE: the write is accepted first (counted), then the burst starts with the new tx_count.
- go while busy is ignored.
- Timer: clog2(TIMEOUT+1) bits, saturating. It counts only in REQ and XFER.

Test Plan:
- Reset during XFER with idx=2 -> spi_start=0, busy=0, tx_count=0, rx_count=0, state IDLE; next go with an empty buffer gives only a done pulse.
- Load 0xA5,0x3C,0xFF; go; master model returns 0x11,0x22,0x33 -> exactly 3 spi_start rises, in order:
  - spi_data 0xA5, 0x3C, 0xFF;
  - done is a single pulse, rx_count=3;
  - three rx_rd_en pops read 0x11,0x22,0x33; rx_count=0.
- Write 9 bytes with DEPTH=8 -> tx_count=8, 9th byte dropped; the burst sends 8 frames.
- go with tx_count=0 -> done high for exactly 1 cycle one cycle later, spi_start never high, busy never high.
- Master model never asserts SS -> err=1 after TIMEOUT+1 cycles in REQ, busy=0, spi_start=0; next go with 1 byte clears err and completes normally.
- Master drops SS, then holds it low forever on byte 2 of 3 -> err=1, rx_count=1, rx_data = byte-1 response; go and wr_en while busy are ignored.
